// File: rtl/effect_seq_pkg.sv
// Shared encodings for the effect sequencer: FSM states, playback modes,
// count range limits and the step result record.
package effect_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_FWD  = 2'd0,
        MODE_REV  = 2'd1,
        MODE_PING = 2'd2,
        MODE_HOLD = 2'd3
    } mode_t;

    localparam logic [2:0] CNT_MIN  = 3'd0;
    localparam logic [2:0] CNT_MAX  = 3'd7;
    localparam logic       DIR_UP   = 1'b0;
    localparam logic       DIR_DOWN = 1'b1;

    typedef struct packed {
        logic [2:0] count;
        logic       dir;
    } step_t;

endpackage

// File: rtl/effect_sequencer_tick_gen.sv
// Base-tick prescaler: counts 0..CLK_DIV-1 while run is high, pulsing tick
// on the last count; holds its value while run is low.
module tick_gen #(
    parameter int CLK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/effect_sequencer.sv
// Effect sequencer: steps a 3-bit pattern index forward, reverse, ping-pong
// or hold at a programmable rate, with pause, abort and one-shot completion.
module effect_sequencer
    import effect_seq_pkg::*;
#(
    parameter int CLK_DIV = 1000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_enable,
    input  logic [1:0] i_mode,
    input  logic [3:0] i_rate,
    input  logic       i_oneshot,
    output logic [2:0] o_count,
    output logic       o_step,
    output logic       o_done,
    output logic       o_blank,
    output logic       o_busy
);

    state_t     state;
    state_t     state_next;
    mode_t      mode_lat;
    logic [3:0] rate_lat;
    logic       oneshot_lat;
    logic       dir;
    logic [3:0] rate_cnt;
    logic       tick;
    logic       presc_clr;
    logic       start_evt;
    logic       step_evt;
    logic       done_evt;
    step_t      adv;

    function automatic step_t advance(input mode_t mode, input logic [2:0] count,
                                      input logic d);
        step_t r;
        r.count = count;
        r.dir   = d;
        case (mode)
            MODE_FWD: r.count = count + 3'd1;
            MODE_REV: r.count = count - 3'd1;
            MODE_PING: begin
                // Ends bounce without repeating the end value.
                if (d == DIR_UP) begin
                    if (count == CNT_MAX) begin
                        r.dir   = DIR_DOWN;
                        r.count = CNT_MAX - 3'd1;
                    end else begin
                        r.count = count + 3'd1;
                    end
                end else begin
                    if (count == CNT_MIN) begin
                        r.dir   = DIR_UP;
                        r.count = CNT_MIN + 3'd1;
                    end else begin
                        r.count = count - 3'd1;
                    end
                end
            end
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic is_terminal(input mode_t mode, input logic [2:0] count,
                                         input logic d);
        case (mode)
            MODE_FWD:  return count == CNT_MAX;
            MODE_REV:  return count == CNT_MIN;
            MODE_PING: return (count == CNT_MIN) && (d == DIR_DOWN);
            default:   return 1'b0;
        endcase
    endfunction

    // Prescaler is held clear whenever the sequencer is idle or being aborted.
    assign presc_clr = i_rst || i_stop || (state == ST_IDLE);

    tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .clk  (i_clk),
        .rst  (presc_clr),
        .run  (state == ST_RUN),
        .tick (tick)
    );

    assign start_evt = (state == ST_IDLE) && i_start && i_enable;
    assign step_evt  = (state == ST_RUN) && tick && (rate_cnt == rate_lat);
    assign done_evt  = step_evt && oneshot_lat && is_terminal(mode_lat, o_count, dir);
    assign adv       = advance(mode_lat, o_count, dir);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (i_stop) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start_evt) state_next = ST_RUN;
                ST_RUN: begin
                    if (done_evt)       state_next = ST_IDLE;
                    else if (!i_enable) state_next = ST_PAUSE;
                end
                ST_PAUSE: if (i_enable) state_next = ST_RUN;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_blank = (state == ST_IDLE);
        o_busy  = (state != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_stop) begin
            o_count     <= CNT_MIN;
            o_step      <= 1'b0;
            o_done      <= 1'b0;
            dir         <= DIR_UP;
            rate_cnt    <= '0;
            oneshot_lat <= 1'b0;
        end else begin
            o_step <= 1'b0;
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    dir      <= DIR_UP;
                    rate_cnt <= '0;
                    o_count  <= CNT_MIN;
                    if (start_evt) begin
                        o_count     <= (mode_t'(i_mode) == MODE_REV) ? CNT_MAX : CNT_MIN;
                        oneshot_lat <= i_oneshot;
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        rate_cnt <= step_evt ? 4'd0 : rate_cnt + 4'd1;
                    end
                    if (done_evt) begin
                        o_done  <= 1'b1;
                        o_count <= CNT_MIN;
                        dir     <= DIR_UP;
                    end else if (step_evt) begin
                        o_step  <= 1'b1;
                        o_count <= adv.count;
                        dir     <= adv.dir;
                    end
                end
                default: ;
            endcase
        end
    end

    // Rate and mode apply per interval: captured at start and at every step.
    always_ff @(posedge i_clk) begin
        if (start_evt || step_evt) begin
            rate_lat <= i_rate;
            mode_lat <= mode_t'(i_mode);
        end
    end

endmodule

// File: tb/tb_effect_sequencer.sv
// Directed self-checking bench for effect_sequencer with CLK_DIV=4.
module tb_effect_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       enable = 1'b1;
    logic [1:0] mode = 2'd0;
    logic [3:0] rate = 4'd0;
    logic       oneshot = 1'b0;
    logic [2:0] count;
    logic       step;
    logic       done;
    logic       blank;
    logic       busy;

    int checks = 0;
    int failures = 0;

    effect_sequencer #(.CLK_DIV(4)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_stop    (stop),
        .i_enable  (enable),
        .i_mode    (mode),
        .i_rate    (rate),
        .i_oneshot (oneshot),
        .o_count   (count),
        .o_step    (step),
        .o_done    (done),
        .o_blank   (blank),
        .o_busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_evt(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(step || done) && n < 64);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    logic [2:0] ping_exp [15] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6,
                                  3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};

    initial begin
        int n;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_count", 32'(count), 0);
        chk("rst_blank", 32'(blank), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_step", 32'(step), 0);
        chk("rst_done", 32'(done), 0);

        // Start ignored while disabled
        enable = 1'b0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        enable = 1'b1;
        chk("start_disabled_busy", 32'(busy), 0);

        // Forward, rate 0: step every 4 cycles
        mode = 2'd0;
        rate = 4'd0;
        pulse_start();
        chk("fwd_busy", 32'(busy), 1);
        chk("fwd_blank", 32'(blank), 0);
        chk("fwd_load", 32'(count), 0);
        for (int i = 1; i <= 9; i++) begin
            repeat (3) begin
                tick();
                chk("fwd_gap_step", 32'(step), 0);
            end
            tick();
            chk("fwd_step", 32'(step), 1);
            chk("fwd_count", 32'(count), 32'(i % 8));
        end

        // Reset mid-run on a cycle that would otherwise step
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_count", 32'(count), 0);
        chk("midrst_blank", 32'(blank), 1);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_step", 32'(step), 0);

        // Ping-pong, rate 0
        mode = 2'd2;
        pulse_start();
        for (int i = 0; i < 15; i++) begin
            wait_evt(n);
            chk("ping_period", 32'(n), 4);
            chk("ping_step", 32'(step), 1);
            chk("ping_count", 32'(count), 32'(ping_exp[i]));
        end
        pulse_stop();
        chk("ping_stop_busy", 32'(busy), 0);

        // One-shot reverse, rate 1: 8-cycle steps, completion leaving 0
        mode    = 2'd1;
        rate    = 4'd1;
        oneshot = 1'b1;
        pulse_start();
        chk("rev_load", 32'(count), 7);
        for (int i = 6; i >= 0; i--) begin
            repeat (7) begin
                tick();
                chk("rev_gap_step", 32'(step), 0);
            end
            tick();
            chk("rev_step", 32'(step), 1);
            chk("rev_count", 32'(count), 32'(i));
        end
        repeat (7) tick();
        tick();
        chk("rev_done", 32'(done), 1);
        chk("rev_done_step", 32'(step), 0);
        chk("rev_done_blank", 32'(blank), 1);
        chk("rev_done_busy", 32'(busy), 0);
        chk("rev_done_count", 32'(count), 0);
        tick();
        chk("rev_done_pulse", 32'(done), 0);

        // Hold with one-shot never completes
        mode = 2'd3;
        rate = 4'd0;
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            wait_evt(n);
            chk("hold_step", 32'(step), 1);
            chk("hold_done", 32'(done), 0);
            chk("hold_count", 32'(count), 0);
        end
        pulse_stop();
        oneshot = 1'b0;

        // Pause 2 cycles into an interval for 10 cycles
        mode = 2'd0;
        pulse_start();
        tick();
        tick();
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("pause_step", 32'(step), 0);
            chk("pause_busy", 32'(busy), 1);
            chk("pause_count", 32'(count), 0);
        end
        enable = 1'b1;
        tick();
        chk("resume_early", 32'(step), 0);
        tick();
        chk("resume_step", 32'(step), 1);
        chk("resume_count", 32'(count), 1);

        // Stop coincident with a step
        repeat (3) tick();
        pulse_stop();
        chk("stop_step", 32'(step), 0);
        chk("stop_done", 32'(done), 0);
        chk("stop_busy", 32'(busy), 0);
        chk("stop_blank", 32'(blank), 1);
        chk("stop_count", 32'(count), 0);
        repeat (8) begin
            tick();
            chk("idle_quiet", 32'(step), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/effect_sequencer.md
EFFECT_SEQUENCER -- requirements
Module: effect_sequencer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1000, giving i_clk cycles per base tick (minimum 2).
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port i_start, input, 1, a pulse that starts a sequence from IDLE.
REQ-005 SHALL have port i_stop, input, 1, a pulse that aborts to IDLE from any state.
REQ-006 SHALL have port i_enable, input, 1, a level; low pauses, high runs.
REQ-007 SHALL have port i_mode, input, 2: 00 forward, 01 reverse, 10 ping-pong, 11 hold.
REQ-008 SHALL have port i_rate, input, 4; step period is (i_rate+1) base ticks.
REQ-009 SHALL have port i_oneshot, input, 1; high means stop after one pass.
REQ-010 SHALL have port o_count, output, 3, the pattern index to the segment pattern decoder.
REQ-011 SHALL have port o_step, output, 1, a one-cycle pulse coincident with each o_count update.
REQ-012 SHALL have port o_done, output, 1, a one-cycle pulse on oneshot completion.
REQ-013 SHALL have port o_blank, output, 1, high while IDLE (display blanked).
REQ-014 SHALL have port o_busy, output, 1, high whenever state is not IDLE.

Function
REQ-015 SHALL implement three states, IDLE, RUN and PAUSE, with every transition registered.
REQ-016 SHALL move IDLE->RUN on i_start&&i_enable; it SHALL ignore i_start in RUN/PAUSE or when i_enable is low.
REQ-017 SHALL latch i_oneshot, and load o_count with 7 (reverse) or 0 (other modes), on the start edge, with direction set to up.
REQ-018 SHALL move RUN->PAUSE when i_enable is low and PAUSE->RUN when it is high; the prescaler and rate counters freeze in PAUSE, and o_count is held.
REQ-019 SHALL move any state->IDLE on i_stop, with priority over start, enable and a coincident step (no o_step, no o_done).
REQ-020 SHALL count the prescaler 0..CLK_DIV-1 only in RUN, with the base tick at CLK_DIV-1 followed by a wrap to 0.
REQ-021 SHALL count base ticks 0..i_rate in the rate counter; a step occurs on the base tick where the count equals the latched rate, which then clears.
REQ-022 SHALL latch i_rate and i_mode at start and at each step, so that changes mid-interval take effect at the next interval.
REQ-023 SHALL step as follows: forward +1 mod 8; reverse -1 mod 8; hold unchanged but o_step still pulses.
REQ-024 SHALL, in ping-pong, step +1 while up and -1 while down; at 7 going up, direction flips and count becomes 6; at 0 going down, direction flips and count becomes 1.
REQ-025 SHALL, with oneshot latched, treat the step leaving the terminal value (forward 7, reverse 0, ping-pong 0 with direction down) as completion: pulse o_done, no o_step, go to IDLE.
REQ-026 SHALL never complete in hold mode, even with oneshot set.
REQ-027 SHALL deliver the first o_step exactly (i_rate+1)*CLK_DIV cycles after the start edge when no pause occurs.
REQ-028 SHALL force o_count to 0, o_blank to 1, and the counters to 0 in IDLE.
REQ-029 SHALL resume the remaining interval after a pause without any restart.

Reset
REQ-030 SHALL, on i_rst high at a clock edge, set state IDLE, o_count 0, o_step 0, o_done 0, o_blank 1, o_busy 0, prescaler 0, rate counter 0 and direction up.
REQ-031 SHALL let reset override all inputs, including mid-sequence and during a coincident step.

Structure
REQ-032 SHALL place the state encoding, the mode encodings and the terminal-value constants in shared package effect_seq_pkg.
REQ-033 SHALL implement the prescaler as sub-module tick_gen (inputs: clock, reset, run; output: tick pulse).
REQ-034 SHALL keep o_count registered and the downstream pattern decoder external.

Verification
REQ-035 SHALL verify reset: assert i_rst mid-RUN -> next cycle o_count=0, o_blank=1, o_busy=0, no o_step.
REQ-036 SHALL verify forward, CLK_DIV=4, rate 0: start -> o_step every 4 cycles, o_count 1,2,...,7,0,1.
REQ-037 SHALL verify ping-pong, rate 0: o_count 1..7,6..0,1, with no repeated value at the ends.
REQ-038 SHALL verify oneshot reverse, rate 1, CLK_DIV=4: o_count 7,6,...,0 every 8 cycles, then o_done at the next step, IDLE, o_blank=1.
REQ-039 SHALL verify pause: drop i_enable 2 cycles into a 4-cycle interval for 10 cycles -> the step arrives 2 cycles after re-enable.
REQ-040 SHALL verify stop coincident with a step cycle -> o_step=0, o_done=0, IDLE next cycle, o_count=0.
